// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler. Arbitrates the single write port between
// pipeline writeback (A) and buffered multi-cycle results (B), and keeps a
// pending-write scoreboard that decode uses to stall on RAW hazards.
module rf_write_scheduler #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            A_VALID,
  output logic            A_READY,
  input  logic [4:0]      A_REG,
  input  logic [XLEN-1:0] A_DATA,
  input  logic            B_VALID,
  output logic            B_READY,
  input  logic [4:0]      B_REG,
  input  logic [XLEN-1:0] B_DATA,
  input  logic            ISSUE_VALID,
  input  logic [4:0]      ISSUE_REG,
  input  logic [4:0]      QUERY_REG1,
  input  logic [4:0]      QUERY_REG2,
  output logic            STALL,
  output logic            WRITE_ENABLE,
  output logic [4:0]      WRITE_REG,
  output logic [XLEN-1:0] DATA_IN
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]      fifo_reg_q  [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;
  logic            we_q, we_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            fifo_empty, fifo_full;
  logic [4:0]      head_reg;
  logic [XLEN-1:0] head_data;
  logic            a_req, force_b, grant_a, grant_b, push, pop;

  // Arbitration: a starved FIFO head overrides A; otherwise A wins, B fills idle slots.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    head_reg   = fifo_reg_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    a_req      = A_VALID & (A_REG != 5'd0);
    force_b    = (starve_q == STARVE_MAX) & ~fifo_empty;
    grant_a    = a_req & ~force_b;
    grant_b    = ~fifo_empty & ~grant_a;
    push       = B_VALID & B_READY;
    pop        = grant_b;
  end

  assign A_READY      = ~force_b;
  assign B_READY      = ~fifo_full & ~RESET;
  assign STALL        = pending_q[QUERY_REG1] | pending_q[QUERY_REG2];
  assign WRITE_ENABLE = we_q;
  assign WRITE_REG    = wreg_q;
  assign DATA_IN      = wdata_q;

  // Next-state for FIFO bookkeeping, starvation counter, scoreboard and write port.
  always_comb begin
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || grant_b) begin
      starve_d = '0;
    end else if (grant_a && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    // Clear is applied before set so a same-edge issue to the same reg stays pending.
    pending_d = pending_q;
    if (grant_b && (head_reg != 5'd0)) pending_d[head_reg] = 1'b0;
    if (ISSUE_VALID && (ISSUE_REG != 5'd0)) pending_d[ISSUE_REG] = 1'b1;
    pending_d[0] = 1'b0;

    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant_a) begin
      we_d    = 1'b1;
      wreg_d  = A_REG;
      wdata_d = A_DATA;
    end else if (grant_b) begin
      we_d    = (head_reg != 5'd0);
      wreg_d  = head_reg;
      wdata_d = head_data;
    end
  end

  // Control and write-port registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates all reads.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= B_REG;
      fifo_data_q[wr_ptr_q] <= B_DATA;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_rf_write_scheduler;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        CLK = 1'b0;
  logic        RESET, A_VALID, B_VALID, ISSUE_VALID;
  logic [4:0]  A_REG, B_REG, ISSUE_REG, QUERY_REG1, QUERY_REG2;
  logic [31:0] A_DATA, B_DATA;
  logic        A_READY, B_READY, STALL, WRITE_ENABLE;
  logic [4:0]  WRITE_REG;
  logic [31:0] DATA_IN;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  rf_write_scheduler #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_REG(A_REG), .A_DATA(A_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_REG(B_REG), .B_DATA(B_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_REG(ISSUE_REG),
    .QUERY_REG1(QUERY_REG1), .QUERY_REG2(QUERY_REG2), .STALL(STALL),
    .WRITE_ENABLE(WRITE_ENABLE), .WRITE_REG(WRITE_REG), .DATA_IN(DATA_IN)
  );

  // Reference model: result queue, pending set, starvation count, write port.
  typedef struct packed { logic [4:0] r; logic [31:0] d; } bent_t;
  bent_t       m_q[$];
  bit [31:0]   m_pend = '0;
  int          m_starve = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_wreg = '0;
  logic [31:0] m_wdata = '0;
  int          m_sz;
  bit          m_force, m_ga, m_gb, m_acc;
  bent_t       m_h, m_e;

  always @(posedge CLK) begin
    if (RESET) begin
      m_q.delete();
      m_pend = '0; m_starve = 0; m_we = 1'b0; m_wreg = '0; m_wdata = '0;
    end else begin
      m_sz    = m_q.size();
      m_force = (m_starve == LIM) && (m_sz > 0);
      m_ga    = A_VALID && (A_REG != 5'd0) && !m_force;
      m_gb    = (m_sz > 0) && !m_ga;
      m_acc   = B_VALID && (m_sz < DEPTH);
      if (m_ga) begin
        m_we = 1'b1; m_wreg = A_REG; m_wdata = A_DATA;
      end else if (m_gb) begin
        m_h = m_q.pop_front();
        m_we = (m_h.r != 5'd0); m_wreg = m_h.r; m_wdata = m_h.d;
        if (m_h.r != 5'd0) m_pend[m_h.r] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (m_sz == 0 || m_gb) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      if (m_acc) begin
        m_e.r = B_REG; m_e.d = B_DATA;
        m_q.push_back(m_e);
      end
      if (ISSUE_VALID && ISSUE_REG != 5'd0) m_pend[ISSUE_REG] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    A_VALID = 0; A_REG = 0; A_DATA = 0;
    B_VALID = 0; B_REG = 0; B_DATA = 0;
    ISSUE_VALID = 0; ISSUE_REG = 0; QUERY_REG1 = 0; QUERY_REG2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1; tick(); tick(); RESET = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1; A_VALID = 1; A_REG = 5; A_DATA = 32'h1; B_VALID = 1; B_REG = 6; B_DATA = 32'h6;
    ISSUE_VALID = 1; ISSUE_REG = 8; QUERY_REG1 = 8;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      n_cmp++; if (WRITE_ENABLE !== 1'b0) begin n_bad++; $display("FAIL reset_we cyc%0d: got %b want 0", i, WRITE_ENABLE); end
      n_cmp++; if (B_READY !== 1'b0) begin n_bad++; $display("FAIL reset_bready cyc%0d: got %b want 0", i, B_READY); end
      n_cmp++; if (STALL !== 1'b0) begin n_bad++; $display("FAIL reset_stall cyc%0d: got %b want 0", i, STALL); end
      n_cmp++; if (A_READY !== 1'b1) begin n_bad++; $display("FAIL reset_aready cyc%0d: got %b want 1", i, A_READY); end
      n_cmp++; if (WRITE_REG !== 5'd0 || DATA_IN !== 32'd0) begin n_bad++; $display("FAIL reset_port cyc%0d: got r%0d/%h want r0/0", i, WRITE_REG, DATA_IN); end
    end
    RESET = 0; #1;
    n_cmp++; if (B_READY !== 1'b1) begin n_bad++; $display("FAIL reset_bready_after: got %b want 1", B_READY); end
    n_cmp++; if (WRITE_ENABLE !== 1'b0) begin n_bad++; $display("FAIL reset_we_after: got %b want 0", WRITE_ENABLE); end
    tick(); #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd5) begin n_bad++; $display("FAIL reset_first_write: got we=%b r%0d want we=1 r5", WRITE_ENABLE, WRITE_REG); end
  endtask

  task automatic test_a_only();
    do_reset();
    A_VALID = 1; A_REG = 5; A_DATA = 32'hDEADBEEF; #1;
    n_cmp++; if (A_READY !== 1'b1) begin n_bad++; $display("FAIL a_ready: got %b want 1", A_READY); end
    tick(); A_REG = 0; A_DATA = 32'h1111; #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd5 || DATA_IN !== 32'hDEADBEEF) begin n_bad++; $display("FAIL a_write: got we=%b r%0d %h want we=1 r5 deadbeef", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    tick(); A_VALID = 0; #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b0 || WRITE_REG !== 5'd5 || DATA_IN !== 32'hDEADBEEF) begin n_bad++; $display("FAIL a_zero_reg: got we=%b r%0d %h want we=0 r5 deadbeef", WRITE_ENABLE, WRITE_REG, DATA_IN); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    ISSUE_VALID = 1; ISSUE_REG = 7; QUERY_REG1 = 7; #1;
    n_cmp++; if (STALL !== 1'b0) begin n_bad++; $display("FAIL sb_stall_pre: got %b want 0", STALL); end
    tick(); ISSUE_VALID = 0; #1;
    n_cmp++; if (STALL !== 1'b1) begin n_bad++; $display("FAIL sb_stall_set: got %b want 1", STALL); end
    B_VALID = 1; B_REG = 7; B_DATA = 32'h12;
    tick(); B_VALID = 0; #1;
    n_cmp++; if (STALL !== 1'b1 || WRITE_ENABLE !== 1'b0) begin n_bad++; $display("FAIL sb_after_push: got stall=%b we=%b want 1 0", STALL, WRITE_ENABLE); end
    tick(); #1;
    n_cmp++; if (STALL !== 1'b0) begin n_bad++; $display("FAIL sb_stall_clear: got %b want 0", STALL); end
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd7 || DATA_IN !== 32'h12) begin n_bad++; $display("FAIL sb_b_write: got we=%b r%0d %h want we=1 r7 12", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    B_VALID = 1; B_REG = 9; B_DATA = 32'h99; QUERY_REG2 = 9;
    tick(); B_VALID = 0; ISSUE_VALID = 1; ISSUE_REG = 9;
    tick(); ISSUE_VALID = 0; #1;
    n_cmp++; if (STALL !== 1'b1 || WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd9) begin n_bad++; $display("FAIL sb_set_wins: got stall=%b we=%b r%0d want 1 1 r9", STALL, WRITE_ENABLE, WRITE_REG); end
    tick(); #1;
    n_cmp++; if (STALL !== 1'b1 || WRITE_ENABLE !== 1'b0) begin n_bad++; $display("FAIL sb_set_hold: got stall=%b we=%b want 1 0", STALL, WRITE_ENABLE); end
  endtask

  task automatic test_starvation();
    do_reset();
    A_VALID = 1; A_REG = 3; A_DATA = 32'd99;
    B_VALID = 1; B_REG = 10; B_DATA = 32'hAB; ISSUE_VALID = 1; ISSUE_REG = 10;
    tick(); B_VALID = 0; ISSUE_VALID = 0;
    for (int i = 0; i < LIM; i++) begin
      A_DATA = 32'(100 + i); #1;
      n_cmp++; if (A_READY !== 1'b1) begin n_bad++; $display("FAIL starve_aready%0d: got %b want 1", i, A_READY); end
      tick(); #1;
      n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd3 || DATA_IN !== 32'(100 + i)) begin n_bad++; $display("FAIL starve_awrite%0d: got we=%b r%0d %0d want we=1 r3 %0d", i, WRITE_ENABLE, WRITE_REG, DATA_IN, 100 + i); end
    end
    n_cmp++; if (A_READY !== 1'b0) begin n_bad++; $display("FAIL starve_forced: got a_ready=%b want 0", A_READY); end
    tick(); A_DATA = 32'd200; #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd10 || DATA_IN !== 32'hAB) begin n_bad++; $display("FAIL starve_bwrite: got we=%b r%0d %h want we=1 r10 ab", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    n_cmp++; if (A_READY !== 1'b1) begin n_bad++; $display("FAIL starve_resume_ready: got %b want 1", A_READY); end
    tick(); #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd3 || DATA_IN !== 32'd200) begin n_bad++; $display("FAIL starve_resume: got we=%b r%0d %0d want we=1 r3 200", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    A_VALID = 0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    A_VALID = 1; A_REG = 3; A_DATA = 32'h3;
    B_VALID = 1; B_REG = 11; B_DATA = 32'h11;
    tick(); B_REG = 12; B_DATA = 32'h22; #1;
    n_cmp++; if (B_READY !== 1'b1) begin n_bad++; $display("FAIL full_ready_one: got %b want 1", B_READY); end
    tick(); B_REG = 13; B_DATA = 32'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (B_READY !== 1'b0) begin n_bad++; $display("FAIL full_bready%0d: got %b want 0", i, B_READY); end
      tick();
    end
    #1;
    n_cmp++; if (B_READY !== 1'b1) begin n_bad++; $display("FAIL full_after_pop: got %b want 1", B_READY); end
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd11 || DATA_IN !== 32'h11) begin n_bad++; $display("FAIL full_order0: got we=%b r%0d %h want we=1 r11 11", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    tick(); B_VALID = 0; A_VALID = 0;
    tick(); #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd12 || DATA_IN !== 32'h22) begin n_bad++; $display("FAIL full_order1: got we=%b r%0d %h want we=1 r12 22", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    tick(); #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b1 || WRITE_REG !== 5'd13 || DATA_IN !== 32'h33) begin n_bad++; $display("FAIL full_order2: got we=%b r%0d %h want we=1 r13 33", WRITE_ENABLE, WRITE_REG, DATA_IN); end
    tick(); #1;
    n_cmp++; if (WRITE_ENABLE !== 1'b0) begin n_bad++; $display("FAIL full_drained: got we=%b want 0", WRITE_ENABLE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    A_VALID = 1; A_REG = 3; A_DATA = 32'h3;
    ISSUE_VALID = 1; ISSUE_REG = 4; B_VALID = 1; B_REG = 20; B_DATA = 32'h1;
    tick(); ISSUE_VALID = 0; B_REG = 21; B_DATA = 32'h2;
    tick(); B_VALID = 0; QUERY_REG1 = 4; #1;
    n_cmp++; if (STALL !== 1'b1) begin n_bad++; $display("FAIL mid_stall_pre: got %b want 1", STALL); end
    RESET = 1; A_VALID = 0;
    tick(); #1;
    n_cmp++; if (STALL !== 1'b0 || WRITE_ENABLE !== 1'b0 || B_READY !== 1'b0) begin n_bad++; $display("FAIL mid_in_reset: got stall=%b we=%b bready=%b want 0 0 0", STALL, WRITE_ENABLE, B_READY); end
    RESET = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      n_cmp++; if (WRITE_ENABLE !== 1'b0 || STALL !== 1'b0) begin n_bad++; $display("FAIL mid_stale%0d: got we=%b stall=%b want 0 0", i, WRITE_ENABLE, STALL); end
    end
  endtask

  task automatic test_random();
    bit exp_ar, exp_br, exp_st;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      RESET       = ($urandom_range(0, 199) == 0);
      A_VALID     = ($urandom_range(0, 99) < 70);
      A_REG       = 5'($urandom_range(0, 31));
      if (m_pend[A_REG]) A_REG = 5'd0;
      A_DATA      = $urandom();
      B_VALID     = ($urandom_range(0, 99) < 45);
      B_REG       = 5'($urandom_range(0, 31));
      B_DATA      = $urandom();
      ISSUE_VALID = ($urandom_range(0, 99) < 30);
      ISSUE_REG   = 5'($urandom_range(0, 31));
      if (m_pend[ISSUE_REG]) ISSUE_VALID = 1'b0;
      QUERY_REG1  = 5'($urandom_range(0, 31));
      QUERY_REG2  = 5'($urandom_range(0, 31));
      #1;
      exp_ar = !((m_starve == LIM) && (m_q.size() != 0));
      exp_br = !RESET && (m_q.size() < DEPTH);
      exp_st = m_pend[QUERY_REG1] | m_pend[QUERY_REG2];
      n_cmp++; if (A_READY !== exp_ar) begin n_bad++; $display("FAIL rnd_aready c%0d: got %b want %b", c, A_READY, exp_ar); end
      n_cmp++; if (B_READY !== exp_br) begin n_bad++; $display("FAIL rnd_bready c%0d: got %b want %b", c, B_READY, exp_br); end
      n_cmp++; if (STALL !== exp_st) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, STALL, exp_st); end
      n_cmp++; if (WRITE_ENABLE !== m_we) begin n_bad++; $display("FAIL rnd_we c%0d: got %b want %b", c, WRITE_ENABLE, m_we); end
      n_cmp++; if (WRITE_REG !== m_wreg || DATA_IN !== m_wdata) begin n_bad++; $display("FAIL rnd_port c%0d: got r%0d %h want r%0d %h", c, WRITE_REG, DATA_IN, m_wreg, m_wdata); end
      tick();
    end
    RESET = 0;
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_scoreboard();
    test_starvation();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
